// File: rtl/sram_sample_fetcher.sv
// Prefetches stereo PCM frames (L at even, R at odd word address) from async SRAM
// into a small FIFO and pops one frame per AUD_CLK rising edge. Macro LOOP_EN: wrap region.
module sram_sample_fetcher #(
    parameter logic [19:0] START_ADDR = 20'h00000,
    parameter logic [19:0] END_ADDR   = 20'hFFFFF,
    parameter int unsigned READ_WAIT  = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        AUD_CLK,
    input  logic        ENABLE,
    inout  wire  [15:0] SRAM_DQ,
    output logic [19:0] SRAM_ADDR,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_WE_N,
    output logic [15:0] LData,
    output logic [15:0] RData,
    output logic        SAMPLE_VALID,
    output logic        UNDERRUN,
    output logic        DONE
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int WW = (READ_WAIT > 0) ? $clog2(READ_WAIT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RD_L, S_RD_R, S_PUSH} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [WW-1:0] r_wait;
    logic [19:0]   r_addr;
    logic [15:0]   r_hold_l;
    logic [15:0]   r_hold_r;
    logic [15:0]   r_fifo_l [FIFO_DEPTH];
    logic [15:0]   r_fifo_r [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          r_aud_s1;
    logic          r_aud_s2;
    logic          r_aud_prev;
    logic [15:0]   r_ldata;
    logic [15:0]   r_rdata;
    logic          r_valid;
    logic          r_underrun;

    logic          w_tick;
    logic          w_wait_last;
    logic          w_push;
    logic          w_pop;
    logic          w_fifo_full;
    logic          w_stop;
    logic          w_last_frame;
    logic [19:0]   w_sram_addr;
    logic          w_ctl_n;

    // The block is a pure reader; the data bus is never driven from here.
    assign SRAM_DQ = 16'hzzzz;

    assign w_tick       = r_aud_s2 & ~r_aud_prev;
    assign w_wait_last  = (r_wait == WW'(READ_WAIT));
    assign w_push       = (r_state == S_PUSH);
    assign w_pop        = w_tick && (r_count != '0);
    assign w_fifo_full  = (r_count == (PW+1)'(FIFO_DEPTH));
    assign w_last_frame = ((r_addr + 20'd1) == END_ADDR);

`ifdef LOOP_EN
    assign w_stop = 1'b0;
    assign DONE   = 1'b0;
`else
    logic r_end;
    logic r_done;
    assign w_stop = r_end;
    assign DONE   = r_done;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_aud_s1   <= 1'b0;
            r_aud_s2   <= 1'b0;
            r_aud_prev <= 1'b0;
        end else begin
            r_aud_s1   <= AUD_CLK;
            r_aud_s2   <= r_aud_s1;
            r_aud_prev <= r_aud_s2;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sram_addr = r_addr;
        w_ctl_n     = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (ENABLE && !w_fifo_full && !w_stop) w_state_nxt = S_RD_L;
            end
            S_RD_L: begin
                w_ctl_n = 1'b0;
                if (w_wait_last) w_state_nxt = S_RD_R;
            end
            S_RD_R: begin
                w_ctl_n     = 1'b0;
                w_sram_addr = r_addr + 20'd1;
                if (w_wait_last) w_state_nxt = S_PUSH;
            end
            S_PUSH:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign SRAM_ADDR = w_sram_addr;
    assign SRAM_CE_N = w_ctl_n;
    assign SRAM_OE_N = w_ctl_n;
    assign SRAM_UB_N = w_ctl_n;
    assign SRAM_LB_N = w_ctl_n;
    assign SRAM_WE_N = 1'b1;

    // Each word is held READ_WAIT+1 cycles; DQ is sampled on the last one.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wait   <= '0;
            r_hold_l <= 16'h0000;
            r_hold_r <= 16'h0000;
        end else if (r_state == S_RD_L || r_state == S_RD_R) begin
            r_wait <= w_wait_last ? '0 : r_wait + 1'b1;
            if (w_wait_last && r_state == S_RD_L) r_hold_l <= SRAM_DQ;
            if (w_wait_last && r_state == S_RD_R) r_hold_r <= SRAM_DQ;
        end else begin
            r_wait <= '0;
        end
    end

`ifdef LOOP_EN
    always_ff @(posedge CLK) begin
        if (RESET)       r_addr <= START_ADDR;
        else if (w_push) r_addr <= w_last_frame ? START_ADDR : r_addr + 20'd2;
    end
`else
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_addr <= START_ADDR;
            r_end  <= 1'b0;
        end else if (w_push) begin
            r_addr <= r_addr + 20'd2;
            if (w_last_frame) r_end <= 1'b1;
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifo_l[r_wr_ptr] <= r_hold_l;
            r_fifo_r[r_wr_ptr] <= r_hold_r;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // An empty tick is an underrun unless the whole region has already been played.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ldata    <= 16'h0000;
            r_rdata    <= 16'h0000;
            r_valid    <= 1'b0;
            r_underrun <= 1'b0;
`ifndef LOOP_EN
            r_done     <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            if (w_pop) begin
                r_ldata <= r_fifo_l[r_rd_ptr];
                r_rdata <= r_fifo_r[r_rd_ptr];
                r_valid <= 1'b1;
            end else if (w_tick) begin
`ifdef LOOP_EN
                r_underrun <= 1'b1;
`else
                if (r_end)        r_done     <= 1'b1;
                else if (!r_done) r_underrun <= 1'b1;
`endif
            end
        end
    end

    assign LData        = r_ldata;
    assign RData        = r_rdata;
    assign SAMPLE_VALID = r_valid;
    assign UNDERRUN     = r_underrun;

endmodule

// File: tb/tb_sram_sample_fetcher.sv
// Directed bench for sram_sample_fetcher: bus timing, streaming, FIFO stall,
// enable-off underrun, reset mid-read and end-of-region (LOOP_EN aware).
module tb_sram_sample_fetcher;

    logic        clk;
    logic [1:0]  rst;
    logic [1:0]  aud;
    logic [1:0]  en;

    wire  [15:0] dq0;
    wire  [15:0] dq1;
    logic [19:0] addr0, addr1;
    logic        ce0, oe0, ub0, lb0, we0;
    logic        ce1, oe1, ub1, lb1, we1;
    logic [15:0] ld0, rd0, ld1, rd1;
    logic        sv0, und0, done0;
    logic        sv1, und1, done1;

    int n_vec;
    int n_err;

    // SRAM model: word[n] = n
    assign dq0 = addr0[15:0];
    assign dq1 = addr1[15:0];

    sram_sample_fetcher u_dut (
        .CLK(clk), .RESET(rst[0]), .AUD_CLK(aud[0]), .ENABLE(en[0]),
        .SRAM_DQ(dq0), .SRAM_ADDR(addr0),
        .SRAM_CE_N(ce0), .SRAM_OE_N(oe0), .SRAM_UB_N(ub0), .SRAM_LB_N(lb0), .SRAM_WE_N(we0),
        .LData(ld0), .RData(rd0), .SAMPLE_VALID(sv0), .UNDERRUN(und0), .DONE(done0)
    );

    sram_sample_fetcher #(.END_ADDR(20'h00007)) u_dut_end (
        .CLK(clk), .RESET(rst[1]), .AUD_CLK(aud[1]), .ENABLE(en[1]),
        .SRAM_DQ(dq1), .SRAM_ADDR(addr1),
        .SRAM_CE_N(ce1), .SRAM_OE_N(oe1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1), .SRAM_WE_N(we1),
        .LData(ld1), .RData(rd1), .SAMPLE_VALID(sv1), .UNDERRUN(und1), .DONE(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset(input int sel, input logic enable);
        @(negedge clk);
        rst[sel] = 1'b1;
        en[sel]  = enable;
        aud[sel] = 1'b0;
        repeat (3) @(negedge clk);
        rst[sel] = 1'b0;
    endtask

    // One AUD_CLK period of 64 CLK cycles; counts SAMPLE_VALID pulses seen.
    task automatic do_tick(input int sel, output int pulses);
        logic s;
        pulses = 0;
        @(negedge clk);
        aud[sel] = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (i == 32) aud[sel] = 1'b0;
            @(negedge clk);
            s = (sel == 0) ? sv0 : sv1;
            if (s) pulses++;
        end
    endtask

    task automatic test_reset;
        rst = 2'b11; en = 2'b11; aud = 2'b00;
        repeat (3) @(negedge clk);
        n_vec++;
        if (addr0 !== 20'h00000) begin n_err++; $display("FAIL reset_addr: got %h exp 00000", addr0); end
        n_vec++;
        if ({ce0, oe0, ub0, lb0, we0} !== 5'b11111) begin
            n_err++; $display("FAIL reset_ctl: got %b exp 11111", {ce0, oe0, ub0, lb0, we0});
        end
        n_vec++;
        if ({ld0, rd0} !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h exp 0", {ld0, rd0}); end
        n_vec++;
        if ({sv0, und0, done0} !== 3'b000) begin
            n_err++; $display("FAIL reset_flags: got %b exp 000", {sv0, und0, done0});
        end
        n_vec++;
        if ({ce1, oe1, ub1, lb1, we1, sv1, und1, done1} !== 8'b11111000) begin
            n_err++; $display("FAIL reset_dut_end: got %b exp 11111000", {ce1, oe1, ub1, lb1, we1, sv1, und1, done1});
        end
    endtask

    task automatic test_bus_timing;
        logic        exp_ce [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [19:0] exp_a  [9] = '{20'd0, 20'd0, 20'd0, 20'd1, 20'd1, 20'd1, 20'd0, 20'd2, 20'd2};
        do_reset(0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            n_vec++;
            if ({ce0, oe0, ub0, lb0} !== {4{exp_ce[i]}} || addr0 !== exp_a[i] || we0 !== 1'b1) begin
                n_err++;
                $display("FAIL bus_cycle%0d: got ctl=%b addr=%h we=%b exp ctl=%b addr=%h we=1",
                         i, {ce0, oe0, ub0, lb0}, addr0, we0, {4{exp_ce[i]}}, exp_a[i]);
            end
        end
    endtask

    task automatic test_stream;
        logic [3:0] hist;
        int p;
        repeat (40) @(negedge clk);
        @(negedge clk);
        aud[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            hist[i] = sv0;
        end
        n_vec++;
        if (hist !== 4'b0100) begin n_err++; $display("FAIL tick_latency: got %b exp 0100", hist); end
        n_vec++;
        if (ld0 !== 16'd0 || rd0 !== 16'd1) begin n_err++; $display("FAIL stream_f0: got %h/%h exp 0/1", ld0, rd0); end
        repeat (28) @(negedge clk);
        aud[0] = 1'b0;
        repeat (32) @(negedge clk);
        for (int k = 1; k < 3; k++) begin
            do_tick(0, p);
            n_vec++;
            if (p !== 1 || ld0 !== 16'(2 * k) || rd0 !== 16'(2 * k + 1)) begin
                n_err++;
                $display("FAIL stream_f%0d: got pulses=%0d %h/%h exp 1 %h/%h", k, p, ld0, rd0, 2 * k, 2 * k + 1);
            end
        end
        n_vec++;
        if (und0 !== 1'b0) begin n_err++; $display("FAIL stream_underrun: got %b exp 0", und0); end
    endtask

    task automatic test_enable_off;
        int p;
        int tot;
        do_reset(0, 1'b0);
        do_tick(0, p);
        tot = p;
        n_vec++;
        if (und0 !== 1'b1) begin n_err++; $display("FAIL enoff_underrun: got %b exp 1", und0); end
        for (int i = 0; i < 9; i++) begin
            do_tick(0, p);
            tot += p;
        end
        n_vec++;
        if (tot !== 0 || ld0 !== 16'd0 || rd0 !== 16'd0) begin
            n_err++; $display("FAIL enoff_data: got pulses=%0d %h/%h exp 0 0/0", tot, ld0, rd0);
        end
        n_vec++;
        if (ce0 !== 1'b1 || addr0 !== 20'd0) begin
            n_err++; $display("FAIL enoff_bus: got ce=%b addr=%h exp 1 00000", ce0, addr0);
        end
    endtask

    task automatic test_fifo_full;
        int busy;
        int n8;
        int n9;
        int p;
        do_reset(0, 1'b1);
        repeat (40) @(negedge clk);
        n_vec++;
        if (addr0 !== 20'd8 || ce0 !== 1'b1) begin
            n_err++; $display("FAIL full_stall: got addr=%h ce=%b exp 00008 1", addr0, ce0);
        end
        busy = 0;
        repeat (20) begin
            @(negedge clk);
            if (ce0 === 1'b0) busy++;
        end
        n_vec++;
        if (busy !== 0) begin n_err++; $display("FAIL full_idle: got %0d read cycles exp 0", busy); end
        n8 = 0; n9 = 0; p = 0;
        @(negedge clk);
        aud[0] = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (i == 32) aud[0] = 1'b0;
            @(negedge clk);
            if (sv0) p++;
            if (ce0 === 1'b0 && addr0 === 20'd8) n8++;
            if (ce0 === 1'b0 && addr0 === 20'd9) n9++;
        end
        n_vec++;
        if (p !== 1 || ld0 !== 16'd0 || rd0 !== 16'd1) begin
            n_err++; $display("FAIL full_pop: got pulses=%0d %h/%h exp 1 0/1", p, ld0, rd0);
        end
        n_vec++;
        if (n8 !== 3 || n9 !== 3 || addr0 !== 20'd10) begin
            n_err++; $display("FAIL full_refetch: got n8=%0d n9=%0d addr=%h exp 3 3 0000a", n8, n9, addr0);
        end
    endtask

    task automatic test_reset_mid_read;
        int p;
        do_reset(0, 1'b0);
        do_tick(0, p);
        n_vec++;
        if (und0 !== 1'b1) begin n_err++; $display("FAIL rst_pre_underrun: got %b exp 1", und0); end
        @(negedge clk);
        en[0] = 1'b1;
        repeat (12) @(negedge clk);
        n_vec++;
        if (addr0 !== 20'd3 || ce0 !== 1'b0) begin
            n_err++; $display("FAIL rst_in_rd_r: got addr=%h ce=%b exp 00003 0", addr0, ce0);
        end
        rst[0] = 1'b1;
        @(negedge clk);
        n_vec++;
        if (addr0 !== 20'd0 || {ce0, oe0, ub0, lb0, we0} !== 5'b11111 || {sv0, und0, done0} !== 3'b000 ||
            {ld0, rd0} !== 32'h0) begin
            n_err++;
            $display("FAIL rst_mid_read: got addr=%h ctl=%b flags=%b data=%h exp 00000 11111 000 0",
                     addr0, {ce0, oe0, ub0, lb0, we0}, {sv0, und0, done0}, {ld0, rd0});
        end
        rst[0] = 1'b0;
        @(negedge clk);
        n_vec++;
        if (addr0 !== 20'd0 || ce0 !== 1'b0) begin
            n_err++; $display("FAIL rst_restart: got addr=%h ce=%b exp 00000 0", addr0, ce0);
        end
        repeat (40) @(negedge clk);
        do_tick(0, p);
        n_vec++;
        if (p !== 1 || ld0 !== 16'd0 || rd0 !== 16'd1) begin
            n_err++; $display("FAIL rst_pop0: got pulses=%0d %h/%h exp 1 0/1", p, ld0, rd0);
        end
        do_tick(0, p);
        n_vec++;
        if (p !== 1 || ld0 !== 16'd2 || rd0 !== 16'd3) begin
            n_err++; $display("FAIL rst_pop1: got pulses=%0d %h/%h exp 1 2/3", p, ld0, rd0);
        end
    endtask

    task automatic test_end_region;
        int p;
        do_reset(1, 1'b1);
        repeat (40) @(negedge clk);
`ifdef LOOP_EN
        for (int i = 0; i < 5; i++) begin
            do_tick(1, p);
            n_vec++;
            if (p !== 1 || ld1 !== 16'((2 * i) % 8) || rd1 !== 16'((2 * i) % 8 + 1)) begin
                n_err++;
                $display("FAIL loop_f%0d: got pulses=%0d %h/%h exp 1 %h/%h", i, p, ld1, rd1, (2 * i) % 8, (2 * i) % 8 + 1);
            end
        end
        n_vec++;
        if (done1 !== 1'b0 || und1 !== 1'b0) begin
            n_err++; $display("FAIL loop_flags: got done=%b und=%b exp 0 0", done1, und1);
        end
`else
        for (int i = 0; i < 4; i++) begin
            do_tick(1, p);
            n_vec++;
            if (p !== 1 || ld1 !== 16'(2 * i) || rd1 !== 16'(2 * i + 1) || done1 !== 1'b0) begin
                n_err++;
                $display("FAIL end_f%0d: got pulses=%0d %h/%h done=%b exp 1 %h/%h 0", i, p, ld1, rd1, done1, 2 * i, 2 * i + 1);
            end
        end
        for (int i = 0; i < 2; i++) begin
            do_tick(1, p);
            n_vec++;
            if (p !== 0 || done1 !== 1'b1 || und1 !== 1'b0 || ld1 !== 16'd6 || rd1 !== 16'd7) begin
                n_err++;
                $display("FAIL end_done%0d: got pulses=%0d done=%b und=%b %h/%h exp 0 1 0 6/7", i, p, done1, und1, ld1, rd1);
            end
        end
        n_vec++;
        if (ce1 !== 1'b1) begin n_err++; $display("FAIL end_bus_idle: got ce=%b exp 1", ce1); end
`endif
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_bus_timing();
        test_stream();
        test_enable_off();
        test_fifo_full();
        test_reset_mid_read();
        test_end_region();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
